// File: rtl/verdict_stream_collector.sv
// Captures active monitor outputs into timestamped records and streams them out
// as a header word followed by one word per active stream.
module verdict_stream_collector #(
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_OUT*WIDTH-1:0]   out_val,
    input  logic [N_OUT-1:0]         out_aktv,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned TS_W  = WIDTH - N_OUT;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned IDX_W = $clog2(N_OUT);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TS_W-1:0]    ts_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               overflow_q;
    logic [DROP_W-1:0]  drop_count_q;

    logic [TS_W-1:0]    ts_mem   [DEPTH];
    logic [N_OUT-1:0]   mask_mem [DEPTH];
    logic [WIDTH-1:0]   val_mem  [DEPTH][N_OUT];

    logic [N_OUT-1:0]   head_mask;
    logic [IDX_W-1:0]   first_idx, next_idx;
    logic               is_last;
    logic               cap, full, push, pop, drop;

    assign head_mask = mask_mem[rd_ptr_q];

    // Descending scan: the final hit is the lowest qualifying bit.
    always_comb begin
        first_idx = '0;
        next_idx  = idx_q;
        is_last   = 1'b1;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (head_mask[i]) begin
                first_idx = IDX_W'(i);
                if (i > int'(idx_q)) begin
                    next_idx = IDX_W'(i);
                    is_last  = 1'b0;
                end
            end
        end
    end

    assign cap  = en & (|out_aktv);
    assign full = (count_q == (PTR_W + 1)'(DEPTH));
    assign pop  = (state_q == StPayload) & m_ready & is_last;
    // A completing record frees its slot in the same cycle a new one arrives.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_q]   <= ts_q;
            mask_mem[wr_ptr_q] <= out_aktv;
            for (int k = 0; k < N_OUT; k++) begin
                val_mem[wr_ptr_q][k] <= out_val[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (en) begin
                ts_q <= ts_q + TS_W'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_q <= drop_count_q + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        state_q <= StHeader;
                    end
                end
                StHeader: begin
                    if (m_ready) begin
                        state_q <= StPayload;
                        idx_q   <= first_idx;
                    end
                end
                StPayload: begin
                    if (m_ready) begin
                        if (is_last) begin
                            state_q <= (count_q != (PTR_W + 1)'(1) || push) ? StHeader : StIdle;
                        end else begin
                            idx_q <= next_idx;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        m_data = '0;
        case (state_q)
            StHeader:  m_data = {ts_mem[rd_ptr_q], head_mask};
            StPayload: m_data = val_mem[rd_ptr_q][idx_q];
            default:   m_data = '0;
        endcase
    end

    assign m_valid    = (state_q != StIdle);
    assign m_last     = (state_q == StPayload) & is_last;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_verdict_stream_collector.sv
// Scoreboard bench for verdict_stream_collector: expected words are queued at
// capture time and compared as the DUT transfers them.
module tb_verdict_stream_collector;

    localparam int N_OUT  = 10;
    localparam int WIDTH  = 64;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;
    localparam int TS_W   = WIDTH - N_OUT;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   en = 1'b0;
    logic [N_OUT*WIDTH-1:0] out_val = '0;
    logic [N_OUT-1:0]       out_aktv = '0;
    logic [WIDTH-1:0]       m_data;
    logic                   m_valid;
    logic                   m_ready = 1'b0;
    logic                   m_last;
    logic                   overflow;
    logic [DROP_W-1:0]      drop_count;
    logic [$clog2(DEPTH):0] fifo_level;

    int tests_run = 0;
    int tests_failed = 0;
    int xfer_count = 0;

    logic [WIDTH:0]   exp_q[$];
    logic [TS_W-1:0]  ts_model;

    logic             stall;
    logic [WIDTH-1:0] hold_data;
    logic             hold_last;

    verdict_stream_collector #(
        .N_OUT (N_OUT),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DROP_W(DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .out_val   (out_val),
        .out_aktv  (out_aktv),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .overflow  (overflow),
        .drop_count(drop_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ts_model <= '0;
        else if (en) ts_model <= ts_model + 1'b1;
    end

    // Inputs change just after posedge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                tests_run++;
                if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
                    tests_failed++;
                    $display("FAIL hold_stable: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             m_valid, m_data, m_last, hold_data, hold_last);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                xfer_count++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_word: data=%h last=%b required no transfer", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        tests_failed++;
                        $display("FAIL stream_word: last=%b data=%h required last=%b data=%h",
                                 m_last, m_data, e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
            stall     = (m_valid === 1'b1) && (m_ready !== 1'b1);
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_vals();
        for (int k = 0; k < N_OUT; k++) begin
            out_val[k*WIDTH +: WIDTH] = {$urandom, $urandom};
        end
    endtask

    task automatic capture(input logic [N_OUT-1:0] mask, input bit accept);
        logic last;
        out_aktv = mask;
        en       = 1'b1;
        if (accept) begin
            exp_q.push_back({1'b0, ts_model, mask});
            for (int k = 0; k < N_OUT; k++) begin
                if (mask[k]) begin
                    last = ((mask >> (k + 1)) == '0);
                    exp_q.push_back({last, out_val[k*WIDTH +: WIDTH]});
                end
            end
        end
        cyc();
        out_aktv = '0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (exp_q.size() == 0 && m_valid === 1'b0) done = 1'b1;
            else cyc();
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d words pending valid=%b required 0 pending valid=0",
                     name, exp_q.size(), m_valid);
        end
        tests_run++;
        if (fifo_level !== '0) begin
            tests_failed++;
            $display("FAIL %s_level: fifo_level=%0d required 0", name, fifo_level);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; out_aktv = '0;
        repeat (2) cyc();
        tests_run++;
        if ({m_valid, m_last, overflow} !== 3'b000 || m_data !== '0 ||
            drop_count !== '0 || fifo_level !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b last=%b ovf=%b data=%h drop=%0d level=%0d required all 0",
                     m_valid, m_last, overflow, m_data, drop_count, fifo_level);
        end
        rst = 1'b0;
        cyc();
        tests_run++;
        if (m_valid !== 1'b0 || fifo_level !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: valid=%b level=%0d required 0 0", m_valid, fifo_level);
        end
    endtask

    task automatic test_single_event();
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 1000 && ts_model != TS_W'(500); i++) cyc();
        tests_run++;
        if (ts_model != TS_W'(500)) begin
            tests_failed++;
            $display("FAIL single_ts_reach: ts=%0d required 500", ts_model);
        end
        out_val = '0;
        out_val[0 +: WIDTH] = 64'd1;
        capture(10'h001, 1'b1);
        tests_run++;
        if (exp_q.size() != 2 || exp_q[0] !== {1'b0, (64'd500 << 10) | 64'd1}) begin
            tests_failed++;
            $display("FAIL single_header_model: size=%0d head=%h required 2 words header %h",
                     exp_q.size(), exp_q[0], (64'd500 << 10) | 64'd1);
        end
        wait_drain("single");
    endtask

    task automatic test_sparse_mask();
        randomize_vals();
        out_val[0*WIDTH +: WIDTH] = -64'sd3;
        out_val[2*WIDTH +: WIDTH] = 64'sd7;
        out_val[9*WIDTH +: WIDTH] = 64'sd42;
        capture(10'h205, 1'b1);
        wait_drain("sparse");
    endtask

    task automatic test_backpressure();
        int start = xfer_count;
        bit done = 1'b0;
        randomize_vals();
        capture(10'h092, 1'b1);
        for (int i = 0; i < 60 && !done; i++) begin
            if (exp_q.size() == 0 && m_valid === 1'b0) done = 1'b1;
            else begin
                m_ready = ~m_ready;
                cyc();
            end
        end
        m_ready = 1'b1;
        tests_run++;
        if (xfer_count - start != 4) begin
            tests_failed++;
            $display("FAIL backpressure_count: transfers=%0d required 4", xfer_count - start);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            randomize_vals();
            capture(10'h001 << r, r < DEPTH);
        end
        tests_run++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL overflow_state: level=%0d ovf=%b drop=%0d required 4 1 1",
                     fifo_level, overflow, drop_count);
        end
        m_ready = 1'b1;
        wait_drain("overflow");
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL overflow_sticky: ovf=%b drop=%0d required 1 1", overflow, drop_count);
        end
    endtask

    task automatic test_full_completion();
        m_ready = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            randomize_vals();
            capture(10'h001, 1'b1);
        end
        cyc();
        m_ready = 1'b1;
        cyc();
        randomize_vals();
        capture(10'h100, 1'b1);
        m_ready = 1'b0;
        tests_run++;
        if (fifo_level !== 3'd4 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL full_completion: level=%0d drop=%0d required 4 1", fifo_level, drop_count);
        end
        m_ready = 1'b1;
        wait_drain("full_completion");
    endtask

    task automatic test_reset_mid_record();
        int start = xfer_count;
        m_ready = 1'b1;
        randomize_vals();
        capture(10'h007, 1'b1);
        for (int i = 0; i < 20 && xfer_count < start + 2; i++) @(negedge clk);
        tests_run++;
        if (xfer_count < start + 2) begin
            tests_failed++;
            $display("FAIL midrec_progress: transfers=%0d required 2", xfer_count - start);
        end
        cyc();
        rst = 1'b1;
        exp_q.delete();
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || fifo_level !== '0) begin
            tests_failed++;
            $display("FAIL midrec_async: valid=%b level=%0d required 0 0", m_valid, fifo_level);
        end
        cyc();
        rst = 1'b0;
        out_val = '0;
        out_val[3*WIDTH +: WIDTH] = 64'hdead_beef;
        capture(10'h008, 1'b1);
        tests_run++;
        if (exp_q[0] !== {1'b0, 54'd0, 10'h008}) begin
            tests_failed++;
            $display("FAIL midrec_ts_model: head=%h required header with ts 0", exp_q[0]);
        end
        wait_drain("midrec");
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_sparse_mask();
        test_backpressure();
        test_overflow();
        test_full_completion();
        test_reset_mid_record();
        repeat (3) cyc();
        tests_run++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL final_idle: pending=%0d valid=%b required 0 0", exp_q.size(), m_valid);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
